// File: rtl/keypad_entry_pkg.sv
// Shared types and key constants for the keypad entry controller.
package keypad_entry_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WR_D,
      S_WR_U,
      S_RDY
   } state_t;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/module_keypad_entry_ctrl_if.sv
// Key-event input and capture-register strobe bundle of the keypad entry controller.
interface module_keypad_entry_ctrl_if;

   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] tecla_d;
   logic       load_d;
   logic       load_u;
   logic       rdy;
   logic       busy;
   logic       err;
   logic [1:0] digit_cnt;

   modport master (
      input  key_valid, key_code,
      output tecla_d, load_d, load_u, rdy, busy, err, digit_cnt
   );

   modport slave (
      output key_valid, key_code,
      input  tecla_d, load_d, load_u, rdy, busy, err, digit_cnt
   );

endinterface

// File: rtl/module_entry_timer.sv
// Idle timeout for a partially typed entry: 25-bit down-counter, expire is the terminal count.
module module_entry_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [24:0] LAST = 25'(TIMEOUT_CYCLES - 1);

   logic [24:0] remain;

   assign expire = enable && (remain == 25'd0);

   // Reload on expiry as well, so a discarded timeout restarts a full period.
   always_ff @(posedge clk) begin
      if (rst) begin
         remain <= LAST;
      end else if (clear || expire) begin
         remain <= LAST;
      end else if (enable) begin
         remain <= remain - 25'd1;
      end
   end

endmodule

// File: rtl/module_keypad_entry_ctrl.sv
// Keypad entry controller: turns key events into tens/units/publish strobes for the capture register.
// Optional idle auto-clear enabled by defining ENTRY_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | waiting for a key; only state that accepts key_valid
// S_WR_D | load_d strobe, tecla_d carries the new tens digit
// S_WR_U | load_u strobe, tecla_d carries the new units digit
// S_RDY  | rdy strobe, capture register publishes {dec,uni}
module module_keypad_entry_ctrl
   import keypad_entry_pkg::*;
#(
   parameter logic [3:0]  CLEAR_CODE     = KEY_CLEAR,
   parameter logic [3:0]  ENTER_CODE     = KEY_ENTER,
   parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
   input  logic                       clk,
   input  logic                       rst,
   module_keypad_entry_ctrl_if.master bus
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   state_t     state;
   logic [3:0] lo_digit;
   logic       expire;
   logic       is_clr;
   logic       is_ent;
   logic       is_dig;
   logic       do_clear;

   assign is_clr = (bus.key_code == CLEAR_CODE);
   assign is_ent = (bus.key_code == ENTER_CODE);
   assign is_dig = is_digit(bus.key_code) && !is_clr && !is_ent;

   // A key in the same cycle as a timeout takes priority over it.
   assign do_clear = bus.key_valid ? is_clr : expire;

`ifdef ENTRY_TIMEOUT_EN
   logic key_acc;
   logic tmr_en;

   assign key_acc = bus.key_valid && (state == S_IDLE) &&
                    (is_clr || (is_ent && bus.digit_cnt != 2'd0) ||
                     (is_dig && bus.digit_cnt != 2'd2));
   assign tmr_en  = (state == S_IDLE) && (bus.digit_cnt != 2'd0);

   module_entry_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (key_acc),
      .enable (tmr_en),
      .expire (expire)
   );
`else
   assign expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         lo_digit      <= 4'd0;
         bus.tecla_d   <= 4'd0;
         bus.load_d    <= 1'b0;
         bus.load_u    <= 1'b0;
         bus.rdy       <= 1'b0;
         bus.busy      <= 1'b0;
         bus.err       <= 1'b0;
         bus.digit_cnt <= 2'd0;
      end else begin
         bus.load_d <= 1'b0;
         bus.load_u <= 1'b0;
         bus.rdy    <= 1'b0;
         bus.err    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (do_clear && (state == S_IDLE)) begin
                  bus.tecla_d   <= 4'd0;
                  bus.load_d    <= 1'b1;
                  lo_digit      <= 4'd0;
                  bus.digit_cnt <= 2'd0;
                  bus.busy      <= 1'b1;
                  state         <= S_WR_D;
               end else if (bus.key_valid && is_ent) begin
                  if (bus.digit_cnt != 2'd0) begin
                     bus.rdy       <= 1'b1;
                     bus.digit_cnt <= 2'd0;
                     lo_digit      <= 4'd0;
                     bus.busy      <= 1'b1;
                     state         <= S_RDY;
                  end else begin
                     bus.err <= 1'b1;
                  end
               end else if (bus.key_valid && is_dig) begin
                  if (bus.digit_cnt == 2'd2) begin
                     bus.err <= 1'b1;
                  end else begin
                     // Right-justify: the previous units digit moves up to tens.
                     bus.tecla_d   <= (bus.digit_cnt == 2'd0) ? 4'd0 : lo_digit;
                     bus.load_d    <= 1'b1;
                     lo_digit      <= bus.key_code;
                     bus.digit_cnt <= bus.digit_cnt + 2'd1;
                     bus.busy      <= 1'b1;
                     state         <= S_WR_D;
                  end
               end else if (bus.key_valid) begin
                  bus.err <= 1'b1;
               end
            end
            S_WR_D: begin
               bus.tecla_d <= lo_digit;
               bus.load_u  <= 1'b1;
               state       <= S_WR_U;
            end
            S_WR_U: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            S_RDY: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_module_keypad_entry_ctrl.sv
// Bench for module_keypad_entry_ctrl: directed vector table, corner sequences, random vs reference model.
module tb_module_keypad_entry_ctrl;
   import keypad_entry_pkg::*;

   localparam int unsigned TO = 10;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   module_keypad_entry_ctrl_if bus();

   module_keypad_entry_ctrl #(
      .CLEAR_CODE     (KEY_CLEAR),
      .ENTER_CODE     (KEY_ENTER),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Downstream capture register fed by the DUT strobes.
   logic [3:0] cap_dec = 4'd0;
   logic [3:0] cap_uni = 4'd0;
   logic [7:0] cap_out = 8'd0;
   always @(posedge clk) begin
      if (bus.load_d) cap_dec <= bus.tecla_d;
      if (bus.load_u) cap_uni <= bus.tecla_d;
      if (bus.rdy)    cap_out <= {cap_dec, cap_uni};
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   function automatic logic [10:0] dut_vec();
      return {bus.tecla_d, bus.load_d, bus.load_u, bus.rdy, bus.err, bus.busy, bus.digit_cnt};
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         v;
      logic [3:0] code;
      logic [10:0] expv;
      bit         chk_out;
      logic [7:0] out;
   } vec_t;

   function automatic vec_t mk(bit v, logic [3:0] code, logic [3:0] t, bit ld, bit lu, bit rd,
                               bit er, bit bz, logic [1:0] cnt, bit chk, logic [7:0] out);
      vec_t x;
      x.v = v; x.code = code; x.expv = {t, ld, lu, rd, er, bz, cnt};
      x.chk_out = chk; x.out = out;
      return x;
   endfunction

   vec_t tbl[27];

   // ---------------- behavioural reference model ----------------
   typedef struct {
      logic [3:0] tecla;
      bit ld, lu, rdy, err, busy;
      logic [1:0] cnt;
   } rec_t;

   rec_t       cur;
   rec_t       pend[$];
   int         digits[$];
   logic [7:0] model_out;
`ifdef ENTRY_TIMEOUT_EN
   int         ticks;
`endif

   function automatic logic [10:0] rec_vec(rec_t r);
      return {r.tecla, r.ld, r.lu, r.rdy, r.err, r.busy, r.cnt};
   endfunction

   function automatic logic [3:0] tens();
      return (digits.size() == 2) ? 4'(digits[0]) : 4'd0;
   endfunction

   function automatic logic [3:0] units();
      return (digits.size() > 0) ? 4'(digits[$]) : 4'd0;
   endfunction

   function automatic rec_t idle_rec(logic [3:0] t);
      rec_t r = '{default: '0};
      r.tecla = t;
      r.cnt   = 2'(digits.size());
      return r;
   endfunction

   function automatic void push_write(logic [3:0] t, logic [3:0] u);
      rec_t r = '{default: '0};
      r.tecla = t; r.ld = 1; r.busy = 1; r.cnt = 2'(digits.size());
      pend.push_back(r);
      r.tecla = u; r.ld = 0; r.lu = 1;
      pend.push_back(r);
   endfunction

   function automatic void model_reset();
      cur = '{default: '0};
      pend.delete();
      digits.delete();
`ifdef ENTRY_TIMEOUT_EN
      ticks = 0;
`endif
   endfunction

   function automatic rec_t model_step(bit v, logic [3:0] code);
      rec_t r;
      bit   acc;
      acc = 0;
      if (cur.busy) begin
         if (pend.size() != 0) r = pend.pop_front();
         else                  r = idle_rec(cur.tecla);
      end else begin
         r = idle_rec(cur.tecla);
         if (v) begin
            if (code == KEY_CLEAR) begin
               digits.delete();
               push_write(4'd0, 4'd0);
               acc = 1;
            end else if (code == KEY_ENTER) begin
               if (digits.size() > 0) begin
                  rec_t q = '{default: '0};
                  model_out = {tens(), units()};
                  digits.delete();
                  q.tecla = cur.tecla; q.rdy = 1; q.busy = 1; q.cnt = 2'd0;
                  pend.push_back(q);
                  acc = 1;
               end else r.err = 1;
            end else if (code <= 4'd9) begin
               if (digits.size() < 2) begin
                  digits.push_back(int'(code));
                  push_write(tens(), units());
                  acc = 1;
               end else r.err = 1;
            end else r.err = 1;
         end
`ifdef ENTRY_TIMEOUT_EN
         if (v) begin
            if (acc) ticks = 0;
            else if (digits.size() > 0) ticks = (ticks == int'(TO) - 1) ? 0 : ticks + 1;
         end else if (digits.size() > 0) begin
            if (ticks == int'(TO) - 1) begin
               ticks = 0;
               digits.delete();
               push_write(4'd0, 4'd0);
            end else ticks++;
         end
`endif
         if (pend.size() != 0) r = pend.pop_front();
      end
      cur = r;
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic step(input bit v, input logic [3:0] c);
      bus.key_valid = v;
      bus.key_code  = c;
      @(posedge clk);
      #1;
      bus.key_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      rec_t  r;
      bit    prev_rdy;
      bit    v;
      logic [3:0] c;
      int    sel;

      tbl[0]  = mk(1, 4'h7, 4'h0, 1, 0, 0, 0, 1, 2'd1, 0, 8'h00);
      tbl[1]  = mk(0, 4'h0, 4'h7, 0, 1, 0, 0, 1, 2'd1, 0, 8'h00);
      tbl[2]  = mk(0, 4'h0, 4'h7, 0, 0, 0, 0, 0, 2'd1, 0, 8'h00);
      tbl[3]  = mk(1, 4'hB, 4'h7, 0, 0, 1, 0, 1, 2'd0, 0, 8'h00);
      tbl[4]  = mk(0, 4'h0, 4'h7, 0, 0, 0, 0, 0, 2'd0, 1, 8'h07);
      tbl[5]  = mk(1, 4'h4, 4'h0, 1, 0, 0, 0, 1, 2'd1, 0, 8'h00);
      tbl[6]  = mk(0, 4'h0, 4'h4, 0, 1, 0, 0, 1, 2'd1, 0, 8'h00);
      tbl[7]  = mk(0, 4'h0, 4'h4, 0, 0, 0, 0, 0, 2'd1, 0, 8'h00);
      tbl[8]  = mk(1, 4'h2, 4'h4, 1, 0, 0, 0, 1, 2'd2, 0, 8'h00);
      tbl[9]  = mk(0, 4'h0, 4'h2, 0, 1, 0, 0, 1, 2'd2, 0, 8'h00);
      tbl[10] = mk(0, 4'h0, 4'h2, 0, 0, 0, 0, 0, 2'd2, 0, 8'h00);
      tbl[11] = mk(1, 4'h9, 4'h2, 0, 0, 0, 1, 0, 2'd2, 0, 8'h00);
      tbl[12] = mk(1, 4'hB, 4'h2, 0, 0, 1, 0, 1, 2'd0, 0, 8'h00);
      tbl[13] = mk(0, 4'h0, 4'h2, 0, 0, 0, 0, 0, 2'd0, 1, 8'h42);
      tbl[14] = mk(1, 4'h5, 4'h0, 1, 0, 0, 0, 1, 2'd1, 0, 8'h00);
      tbl[15] = mk(1, 4'h6, 4'h5, 0, 1, 0, 0, 1, 2'd1, 0, 8'h00);
      tbl[16] = mk(0, 4'h0, 4'h5, 0, 0, 0, 0, 0, 2'd1, 0, 8'h00);
      tbl[17] = mk(1, 4'hB, 4'h5, 0, 0, 1, 0, 1, 2'd0, 0, 8'h00);
      tbl[18] = mk(0, 4'h0, 4'h5, 0, 0, 0, 0, 0, 2'd0, 1, 8'h05);
      tbl[19] = mk(1, 4'hB, 4'h5, 0, 0, 0, 1, 0, 2'd0, 0, 8'h00);
      tbl[20] = mk(1, 4'hE, 4'h5, 0, 0, 0, 1, 0, 2'd0, 0, 8'h00);
      tbl[21] = mk(1, 4'h3, 4'h0, 1, 0, 0, 0, 1, 2'd1, 0, 8'h00);
      tbl[22] = mk(0, 4'h0, 4'h3, 0, 1, 0, 0, 1, 2'd1, 0, 8'h00);
      tbl[23] = mk(0, 4'h0, 4'h3, 0, 0, 0, 0, 0, 2'd1, 0, 8'h00);
      tbl[24] = mk(1, 4'hA, 4'h0, 1, 0, 0, 0, 1, 2'd0, 0, 8'h00);
      tbl[25] = mk(0, 4'h0, 4'h0, 0, 1, 0, 0, 1, 2'd0, 0, 8'h00);
      tbl[26] = mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 2'd0, 0, 8'h00);

      do_reset();
      check("reset_outputs", 32'(dut_vec()), 32'd0);

      for (int i = 0; i < 27; i++) begin
         step(tbl[i].v, tbl[i].code);
         check($sformatf("tbl[%0d]", i), 32'(dut_vec()), 32'(tbl[i].expv));
         if (tbl[i].chk_out) check($sformatf("tbl_out[%0d]", i), 32'(cap_out), 32'(tbl[i].out));
      end

      // Reset in the middle of a write sequence.
      do_reset();
      step(1, 4'h8);
      check("rst_mid_wr_d", 32'(dut_vec()), 32'({4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1}));
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_outputs", 32'(dut_vec()), 32'd0);
      rst = 1'b0;
      step(0, 4'h0);
      check("rst_no_load_u", 32'(dut_vec()), 32'd0);
      step(1, KEY_ENTER);
      check("rst_cnt_cleared", 32'(dut_vec()), 32'({4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0}));

`ifdef ENTRY_TIMEOUT_EN
      begin
         int found;
         do_reset();
         step(1, 4'h1);
         found = 0;
         for (int k = 1; k <= 20 && found == 0; k++) begin
            step(0, 4'h0);
            if (bus.load_d) begin
               found = k;
               check("timeout_tens", 32'(bus.tecla_d), 32'd0);
            end
         end
         check("timeout_edge", 32'(found), 32'(2 + TO));
         step(0, 4'h0);
         check("timeout_units", 32'(dut_vec()), 32'({4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0}));
      end
`endif

      // Random stimulus against the reference model.
      do_reset();
      prev_rdy = 0;
      for (int i = 0; i < 800; i++) begin
         v   = ($urandom_range(0, 1) == 0);
         sel = $urandom_range(0, 9);
         if (sel <= 5)      c = 4'($urandom_range(0, 9));
         else if (sel == 6) c = KEY_CLEAR;
         else if (sel <= 8) c = KEY_ENTER;
         else               c = 4'($urandom_range(12, 15));
         step(v, c);
         r = model_step(v, c);
         check($sformatf("rand[%0d]", i), 32'(dut_vec()), 32'(rec_vec(r)));
         if (prev_rdy) check($sformatf("rand_out[%0d]", i), 32'(cap_out), 32'(model_out));
         prev_rdy = r.rdy;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/module_keypad_entry_ctrl.md
Name: module_keypad_entry_ctrl

Overview:
Upstream controller for the two-digit keypad capture register. It takes debounced key events from the keypad decoder, tracks how many digits (0..2) have been entered, and handles clear ('*') and enter ('#') keys. It drives the capture register's tecla_d, load_d, load_u and rdy strobes so that the register always holds the right-justified entered value, with tens in dec and units in uni. It sits between the keypad scanner/debouncer and the capture register.

Parameters:
CLEAR_CODE, 4'hA, key code treated as clear.
ENTER_CODE, 4'hB, key code treated as enter.
TIMEOUT_CYCLES, 27_000_000, idle cycles before auto-clear. Used only when ENTRY_TIMEOUT_EN is defined; must be >= 2.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
key_valid  input  1  one-cycle pulse: key_code is valid this cycle.
key_code  input  4  decoded key: 0-9 are digits, CLEAR_CODE, ENTER_CODE; any other code is invalid.
tecla_d  output  4  data value for the capture register, registered.
load_d  output  1  one-cycle strobe: write tecla_d into tens.
load_u  output  1  one-cycle strobe: write tecla_d into units.
rdy  output  1  one-cycle strobe: publish {dec,uni}.
busy  output  1  high whenever the FSM is not in S_IDLE.
err  output  1  one-cycle pulse: a key was rejected.
digit_cnt  output  2  number of digits entered (0, 1 or 2).

Behaviour:
- Reset is synchronous and active-high on rst. The clock is clk.
- Reset values: state S_IDLE; tecla_d=0, load_d=0, load_u=0, rdy=0, err=0, digit_cnt=0. Internal lo_digit=0.
- Reset mid-sequence aborts immediately. No strobe is asserted in the cycle after reset.
- All outputs are registered. At most one of load_d, load_u or rdy is high in any cycle.
- FSM states: S_IDLE, S_WR_D, S_WR_U, S_RDY.
- key_valid is acted on only in S_IDLE. Keys arriving while busy=1 are dropped silently, with no err.
- Decisions in S_IDLE, for a key sampled at cycle n:
  - Digit k, digit_cnt=0: next={0,k}, lo_digit=k, digit_cnt=1.
  - Digit k, digit_cnt=1: next={lo_digit,k}, lo_digit=k, digit_cnt=2.
  - Digit, digit_cnt=2: rejected, err=1 at n+1, nothing else changes.
  - CLEAR_CODE: next={0,0}, lo_digit=0, digit_cnt=0. Clear is accepted at any count.
  - ENTER_CODE, digit_cnt>0: go to S_RDY, digit_cnt=0, lo_digit=0.
  - ENTER_CODE, digit_cnt=0: rejected with err.
  - Any other code: rejected with err.
- Write sequence for next={t,u}:
  - Cycle n+1: S_WR_D, load_d=1, tecla_d=t.
  - Cycle n+2: S_WR_U, load_u=1, tecla_d=u.
  - Cycle n+3: back in S_IDLE, ready to accept a key.
- Enter sequence: cycle n+1 is S_RDY with rdy=1. S_IDLE resumes at n+2. The capture register's out updates at n+2.
- tecla_d holds its last value when no strobe is active.
- digit_cnt updates at n+1.

Optional Feature:
Macro: ENTRY_TIMEOUT_EN.
- Defined: a 25-bit idle counter clears on every accepted key and on reset. It counts only while in S_IDLE with digit_cnt>0. When it reaches TIMEOUT_CYCLES-1, the block runs the clear write sequence (0 into tens, then 0 into units), sets digit_cnt=0 and resets the counter. If a key arrives in that same cycle, the key wins and the timeout is discarded.
- Not defined: no counter, and entries never expire.

Decomposition:
- Package keypad_entry_pkg holds:
  - the state_t enum (S_IDLE, S_WR_D, S_WR_U, S_RDY);
  - the constants KEY_CLEAR=4'hA and KEY_ENTER=4'hB;
  - the function is_digit(code).
- Sub-module module_entry_timer (the idle counter with a clear input and an expire pulse) is instantiated only under ENTRY_TIMEOUT_EN.

Test Plan:
1. Reset, then key 7 -> load_d with tecla_d=0 at n+1, load_u with tecla_d=7 at n+2, digit_cnt=1. Then enter -> rdy, and capture out=8'h07.
2. Keys 4 then 2, then enter -> second write sequence is load_d tecla_d=4, load_u tecla_d=2. rdy once; out=8'h42; digit_cnt=0 after enter.
3. Keys 4, 2, 9 -> the 9 gives err pulse, no strobe, digit_cnt stays 2. Enter -> out=8'h42.
4. Key 5 at n, and key 6 at n+1 (busy) -> the 6 is dropped, no err, only one write sequence. Enter -> out=8'h05.
5. Enter with no digits, and code 4'hE -> err each time, no strobes. Key 3 then clear -> load_d 0, load_u 0, digit_cnt=0.
6. rst asserted during S_WR_D of key 8 -> no load_u follows, all outputs 0. With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=10, a digit followed by 10 idle cycles produces a zero write sequence.
